// File: rtl/vip_fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one source at a time a burst of up to
// C_BURST_LEN beats into a shared FIFO, tagging each beat with its source ID.
module vip_fifo_wr_arbiter #(
  parameter int C_NUM_SRC    = 4,
  parameter int C_DATA_WIDTH = 8,
  parameter int C_ID_WIDTH   = 2,
  parameter int C_FIFO_DEPTH = 16,
  parameter int C_CNT_WIDTH  = 5,
  parameter int C_BURST_LEN  = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [C_NUM_SRC-1:0]                src_req,
  input  logic [C_NUM_SRC-1:0]                src_valid,
  input  logic [C_NUM_SRC-1:0]                src_last,
  input  logic [C_NUM_SRC*C_DATA_WIDTH-1:0]   src_data,
  output logic [C_NUM_SRC-1:0]                src_ready,
  output logic [C_NUM_SRC-1:0]                grant,
  output logic                                fifo_wr_en,
  output logic [C_ID_WIDTH+C_DATA_WIDTH-1:0]  fifo_din,
  input  logic                                fifo_full,
  input  logic [C_CNT_WIDTH-1:0]              fifo_data_count,
  output logic                                busy
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  localparam logic [C_CNT_WIDTH:0]   BURST_EXT = (C_CNT_WIDTH+1)'(C_BURST_LEN);
  localparam logic [C_CNT_WIDTH:0]   DEPTH_EXT = (C_CNT_WIDTH+1)'(C_FIFO_DEPTH);
  localparam logic [C_CNT_WIDTH-1:0] LAST_BEAT = C_CNT_WIDTH'(C_BURST_LEN-1);
  localparam logic [C_ID_WIDTH:0]    NSRC_EXT  = (C_ID_WIDTH+1)'(C_NUM_SRC);
  localparam logic [C_ID_WIDTH-1:0]  LAST_ID   = C_ID_WIDTH'(C_NUM_SRC-1);

  logic [0:0]              state;
  logic [C_ID_WIDTH-1:0]   rr_ptr;
  logic [C_ID_WIDTH-1:0]   cur_id;
  logic [C_CNT_WIDTH-1:0]  beat_cnt;

  logic                    room;
  logic                    pick_vld;
  logic [C_ID_WIDTH-1:0]   pick_id;
  logic [C_NUM_SRC-1:0]    pick_oh;
  logic                    sel_valid;
  logic                    sel_last;
  logic [C_DATA_WIDTH-1:0] sel_data;
  logic                    accept;
  logic                    burst_end;

  // Room is judged one bit wider than the count so the sum cannot wrap.
  assign room = ({1'b0, fifo_data_count} + BURST_EXT) <= DEPTH_EXT;

  always_comb begin : rr_pick
    logic [C_ID_WIDTH:0]   sum;
    logic [C_ID_WIDTH-1:0] idx;
    pick_vld = 1'b0;
    pick_id  = '0;
    sum      = '0;
    idx      = '0;
    for (int i = 0; i < C_NUM_SRC; i++) begin
      sum = {1'b0, rr_ptr} + (C_ID_WIDTH+1)'(i);
      if (sum >= NSRC_EXT) sum = sum - NSRC_EXT;
      idx = sum[C_ID_WIDTH-1:0];
      if (!pick_vld && src_req[idx]) begin
        pick_vld = 1'b1;
        pick_id  = idx;
      end
    end
  end

  assign pick_oh = C_NUM_SRC'(1) << pick_id;

  // One-hot grant steers the granted lane; nothing is selected while idle.
  always_comb begin : lane_mux
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < C_NUM_SRC; i++) begin
      sel_valid = sel_valid | (src_valid[i] & grant[i]);
      sel_last  = sel_last  | (src_last[i]  & grant[i]);
      sel_data  = sel_data  | (src_data[i*C_DATA_WIDTH +: C_DATA_WIDTH] & {C_DATA_WIDTH{grant[i]}});
    end
  end

  assign busy       = (state == ST_BURST);
  assign accept     = busy && sel_valid && !fifo_full;
  assign burst_end  = accept && (sel_last || (beat_cnt == LAST_BEAT));
  assign src_ready  = (busy && !fifo_full) ? grant : '0;
  assign fifo_wr_en = accept;
  assign fifo_din   = busy ? {cur_id, sel_data} : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      cur_id   <= '0;
      beat_cnt <= '0;
    end else if (state == ST_IDLE) begin
      if (pick_vld && room) begin
        state    <= ST_BURST;
        grant    <= pick_oh;
        cur_id   <= pick_id;
        beat_cnt <= '0;
      end
    end else begin
      if (burst_end) begin
        state    <= ST_IDLE;
        grant    <= '0;
        rr_ptr   <= (cur_id == LAST_ID) ? '0 : cur_id + 1'b1;
        beat_cnt <= '0;
      end else if (accept) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vip_fifo_wr_arbiter.sv
// Bench for vip_fifo_wr_arbiter: vector table, directed fairness/length-cap
// sequences, and randomized traffic against a queue-based reference model.
module tb_vip_fifo_wr_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = 2;
  localparam int BL  = 4;
  localparam int DEP = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   src_req, src_valid, src_last, src_ready, grant;
  logic [N*W-1:0] src_data;
  logic           fifo_wr_en, fifo_full, busy;
  logic [IDW+W-1:0] fifo_din;
  logic [4:0]     fifo_data_count;

  always #5 clk = ~clk;

  vip_fifo_wr_arbiter #(
    .C_NUM_SRC(N), .C_DATA_WIDTH(W), .C_ID_WIDTH(IDW),
    .C_FIFO_DEPTH(DEP), .C_CNT_WIDTH(5), .C_BURST_LEN(BL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .src_req(src_req), .src_valid(src_valid),
    .src_last(src_last), .src_data(src_data), .src_ready(src_ready),
    .grant(grant), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
    .fifo_full(fifo_full), .fifo_data_count(fifo_data_count), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst_n;
    logic [3:0] req, valid, last;
    logic [7:0] d;
    logic       full;
    logic [4:0] cnt;
    logic [3:0] grant;
    logic       wr;
    logic [1:0] id;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic r, logic [3:0] rq, logic [3:0] v, logic [3:0] l,
                              logic [7:0] d, logic f, logic [4:0] c,
                              logic [3:0] g, logic wr, logic [1:0] id);
    vec_t x;
    x.rst_n = r; x.req = rq; x.valid = v; x.last = l; x.d = d; x.full = f;
    x.cnt = c; x.grant = g; x.wr = wr; x.id = id;
    return x;
  endfunction

  typedef struct { logic [7:0] d; logic last; } beat_t;
  beat_t sq[N][$];

  int m_cur, m_rr, m_cnt;
  int dut_grants[$];
  int dut_wr_cnt;
  logic [N-1:0] prev_grant;

  task automatic do_reset();
    rst_n = 1'b0; src_req = '0; src_valid = '0; src_last = '0; src_data = '0;
    fifo_full = 1'b0; fifo_data_count = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_cur = -1; m_rr = 0; m_cnt = 0;
    prev_grant = '0; dut_wr_cnt = 0;
    dut_grants.delete();
    for (int i = 0; i < N; i++) sq[i].delete();
  endtask

  task automatic add_burst(input int src, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.d = 8'($urandom);
      b.last = (k == len - 1);
      sq[src].push_back(b);
    end
  endtask

  task automatic run_cycles(input int ncyc, input bit rnd);
    logic [N-1:0] exp_g;
    logic         exp_wr;
    beat_t        bt;
    int           cnt_i;
    for (int c = 0; c < ncyc; c++) begin
      if (rnd)
        for (int i = 0; i < N; i++)
          if (sq[i].size() == 0 && $urandom_range(0, 3) == 0) add_burst(i, $urandom_range(1, 6));
      fifo_full = rnd ? ($urandom_range(0, 6) == 0) : 1'b0;
      cnt_i = rnd ? ($urandom_range(0, 1) == 1 ? $urandom_range(0, 12) : $urandom_range(0, 16)) : 0;
      fifo_data_count = 5'(cnt_i);
      for (int i = 0; i < N; i++) begin
        src_req[i]   = (sq[i].size() != 0);
        src_valid[i] = src_req[i] && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
        src_last[i]  = src_req[i] ? sq[i][0].last : 1'b0;
        src_data[i*W +: W] = src_req[i] ? sq[i][0].d : 8'($urandom);
      end
      @(negedge clk);
      exp_g  = (m_cur >= 0) ? N'(1 << m_cur) : '0;
      exp_wr = (m_cur >= 0) && src_valid[m_cur] && !fifo_full;
      chk($sformatf("rnd grant c%0d", c), 32'(grant), 32'(exp_g));
      chk($sformatf("rnd busy c%0d", c), 32'(busy), 32'(m_cur >= 0));
      chk($sformatf("rnd ready c%0d", c), 32'(src_ready), 32'(fifo_full ? '0 : exp_g));
      chk($sformatf("rnd wr c%0d", c), 32'(fifo_wr_en), 32'(exp_wr));
      if (exp_wr)
        chk($sformatf("rnd din c%0d", c), 32'(fifo_din), 32'({2'(m_cur), sq[m_cur][0].d}));
      if (grant != '0 && prev_grant == '0)
        for (int i = 0; i < N; i++) if (grant[i]) dut_grants.push_back(i);
      prev_grant = grant;
      if (fifo_wr_en) dut_wr_cnt++;
      if (m_cur >= 0) begin
        if (exp_wr) begin
          bt = sq[m_cur].pop_front();
          m_cnt++;
          if (bt.last || m_cnt == BL) begin
            m_rr  = (m_cur + 1) % N;
            m_cur = -1;
          end
        end
      end else if (src_req != '0 && cnt_i + BL <= DEP) begin
        for (int k = 0; k < N; k++)
          if (m_cur < 0 && src_req[(m_rr + k) % N]) begin
            m_cur = (m_rr + k) % N;
            m_cnt = 0;
          end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [IDW+W-1:0] exp_din;
    int exp_order[$];

    rst_n = 1'b0; src_req = '0; src_valid = '0; src_last = '0; src_data = '0;
    fifo_full = 1'b0; fifo_data_count = '0;
    @(posedge clk); #1;

    // rst, req, valid, last, data, full, count | grant, wr, id
    vt.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 8'h00, 0, 5'd0,  4'b0000, 0, 0));
    vt.push_back(mk(1, 4'b0100, 4'b0000, 4'b0000, 8'h00, 0, 5'd0,  4'b0000, 0, 0));
    vt.push_back(mk(1, 4'b0100, 4'b0100, 4'b0000, 8'h0E, 0, 5'd0,  4'b0100, 1, 2));
    vt.push_back(mk(1, 4'b0100, 4'b0100, 4'b0000, 8'h0F, 0, 5'd0,  4'b0100, 1, 2));
    vt.push_back(mk(1, 4'b0100, 4'b0100, 4'b0000, 8'h10, 0, 5'd0,  4'b0100, 1, 2));
    vt.push_back(mk(1, 4'b0100, 4'b0100, 4'b0100, 8'h11, 0, 5'd0,  4'b0100, 1, 2));
    vt.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 8'h00, 0, 5'd0,  4'b0000, 0, 0));
    vt.push_back(mk(1, 4'b1111, 4'b0000, 4'b0000, 8'h00, 0, 5'd13, 4'b0000, 0, 0));
    vt.push_back(mk(1, 4'b1111, 4'b0000, 4'b0000, 8'h00, 0, 5'd13, 4'b0000, 0, 0));
    vt.push_back(mk(1, 4'b1111, 4'b0000, 4'b0000, 8'h00, 0, 5'd12, 4'b0000, 0, 0));
    vt.push_back(mk(1, 4'b1111, 4'b1111, 4'b0000, 8'h20, 0, 5'd12, 4'b1000, 1, 3));
    vt.push_back(mk(1, 4'b1111, 4'b1111, 4'b0000, 8'h21, 1, 5'd12, 4'b1000, 0, 3));
    vt.push_back(mk(1, 4'b1111, 4'b1111, 4'b0000, 8'h21, 1, 5'd12, 4'b1000, 0, 3));
    vt.push_back(mk(1, 4'b1111, 4'b1111, 4'b0000, 8'h21, 1, 5'd12, 4'b1000, 0, 3));
    vt.push_back(mk(1, 4'b1111, 4'b1111, 4'b0000, 8'h21, 0, 5'd12, 4'b1000, 1, 3));
    vt.push_back(mk(0, 4'b1111, 4'b1111, 4'b0000, 8'h22, 0, 5'd12, 4'b1000, 1, 3));
    vt.push_back(mk(1, 4'b1001, 4'b0000, 4'b0000, 8'h00, 0, 5'd0,  4'b0000, 0, 0));
    vt.push_back(mk(1, 4'b1001, 4'b0001, 4'b0001, 8'h40, 0, 5'd0,  4'b0001, 1, 0));
    vt.push_back(mk(1, 4'b1000, 4'b0000, 4'b0000, 8'h00, 0, 5'd0,  4'b0000, 0, 0));
    vt.push_back(mk(1, 4'b1000, 4'b1000, 4'b1000, 8'h50, 0, 5'd0,  4'b1000, 1, 3));
    vt.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 8'h00, 0, 5'd0,  4'b0000, 0, 0));

    for (int k = 0; k < vt.size(); k++) begin
      rst_n = vt[k].rst_n; src_req = vt[k].req; src_valid = vt[k].valid;
      src_last = vt[k].last; fifo_full = vt[k].full; fifo_data_count = vt[k].cnt;
      for (int i = 0; i < N; i++) src_data[i*W +: W] = vt[k].d + 8'(i);
      @(negedge clk);
      exp_din = (vt[k].grant != '0) ? {vt[k].id, vt[k].d + 8'(vt[k].id)} : '0;
      chk($sformatf("vec%0d grant", k), 32'(grant), 32'(vt[k].grant));
      chk($sformatf("vec%0d busy", k), 32'(busy), 32'(vt[k].grant != '0));
      chk($sformatf("vec%0d wr_en", k), 32'(fifo_wr_en), 32'(vt[k].wr));
      chk($sformatf("vec%0d ready", k), 32'(src_ready), 32'(vt[k].full ? 4'b0000 : vt[k].grant));
      chk($sformatf("vec%0d din", k), 32'(fifo_din), 32'(exp_din));
      @(posedge clk); #1;
    end

    // All four sources request continuously with 4-beat bursts.
    do_reset();
    add_burst(0, 4); add_burst(0, 4); add_burst(1, 4); add_burst(2, 4); add_burst(3, 4);
    run_cycles(30, 1'b0);
    exp_order = '{0, 1, 2, 3, 0};
    chk("fair n_grants", 32'(dut_grants.size()), 32'(exp_order.size()));
    for (int i = 0; i < exp_order.size() && i < dut_grants.size(); i++)
      chk($sformatf("fair order%0d", i), 32'(dut_grants[i]), 32'(exp_order[i]));
    chk("fair writes", 32'(dut_wr_cnt), 32'd20);

    // Six beats without an early last: capped at four, then two more.
    do_reset();
    add_burst(1, 6);
    run_cycles(15, 1'b0);
    exp_order = '{1, 1};
    chk("cap n_grants", 32'(dut_grants.size()), 32'(exp_order.size()));
    for (int i = 0; i < exp_order.size() && i < dut_grants.size(); i++)
      chk($sformatf("cap order%0d", i), 32'(dut_grants[i]), 32'(exp_order[i]));
    chk("cap writes", 32'(dut_wr_cnt), 32'd6);
    chk("cap drained", 32'(sq[1].size()), 32'd0);

    do_reset();
    run_cycles(3000, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vip_fifo_wr_arbiter.md
Name: vip_fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one sync FIFO between C_NUM_SRC pixel/packet sources in the video image processor.
- Grants one source at a time for a burst of up to C_BURST_LEN beats, and only when the FIFO has room for a whole burst.
- Steers the granted source's data, tagged with its source ID, onto the FIFO write port, with beat-level backpressure from the FIFO full flag.
- Sits between the per-channel capture/filter stages and the shared output FIFO.

Parameters:
- C_NUM_SRC, 4, number of requesting sources (2..8).
- C_DATA_WIDTH, 8, data width per source.
- C_ID_WIDTH, 2, source ID tag width; must satisfy 2^C_ID_WIDTH >= C_NUM_SRC.
- C_FIFO_DEPTH, 16, depth of the attached FIFO.
- C_CNT_WIDTH, 5, width of the FIFO data_count input (clogb2(C_FIFO_DEPTH-1)+1).
- C_BURST_LEN, 4, maximum beats per grant (1..C_FIFO_DEPTH).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- src_req  in  C_NUM_SRC  per-source request; level, held until the source's burst is served.
- src_valid  in  C_NUM_SRC  per-source beat valid.
- src_last  in  C_NUM_SRC  marks the final beat of a source's burst.
- src_data  in  C_NUM_SRC*C_DATA_WIDTH  flattened data; source i occupies bits [i*C_DATA_WIDTH +: C_DATA_WIDTH].
- src_ready  out  C_NUM_SRC  per-source beat accept.
- grant  out  C_NUM_SRC  one-hot current grant.
- fifo_wr_en  out  1  FIFO write enable.
- fifo_din  out  C_ID_WIDTH+C_DATA_WIDTH  {src_id, data}.
- fifo_full  in  1  FIFO full flag.
- fifo_data_count  in  C_CNT_WIDTH  FIFO occupancy.
- busy  out  1  high while in BURST.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE; grant=0; rr_ptr=0; beat_cnt=0; busy=0.
  - src_ready=0; fifo_wr_en=0; fifo_din=0.
  - Reset mid-burst aborts the burst; no further writes occur; the source must re-request.
- Room check: room = (fifo_data_count + C_BURST_LEN <= C_FIFO_DEPTH). Evaluated at C_CNT_WIDTH+1 bits, with no overflow.
- IDLE:
  - If |src_req and room: pick the first requester searching from rr_ptr upward with wrap-around.
  - Register grant one-hot and cur_id; beat_cnt=0; go to BURST.
  - Latency: request sampled at edge t, grant/busy high from t+1.
  - If no request or no room: stay in IDLE, grant=0.
- BURST:
  - src_ready[g] = ~fifo_full (combinational); all other src_ready bits = 0.
  - Beat accepted when src_valid[g] & src_ready[g].
  - fifo_wr_en = accepted beat (combinational, same cycle).
  - fifo_din = {cur_id, src_data[g]}, combinational.
  - Each accepted beat increments beat_cnt.
  - Burst ends on an accepted beat with src_last[g]=1 OR beat_cnt==C_BURST_LEN-1.
    - On that edge: grant<=0, busy<=0, rr_ptr<=(g+1) mod C_NUM_SRC, state<=IDLE.
  - Minimum one IDLE cycle between bursts; no back-to-back grant.
  - src_req deassertion during BURST is ignored; the burst ends only by the last/length rule.
  - Invalid cycles (src_valid=0) and full cycles produce no write and no count change; the grant is held indefinitely.
- fifo_wr_en is never asserted while fifo_full=1.
- fifo_din is unconstrained when fifo_wr_en=0; the implementation drives the granted source's tagged data in BURST and 0 in IDLE.
- Fairness: with all sources requesting continuously, grant order is 0,1,2,3,0,… .
- Starvation bound: a requesting source waits at most C_NUM_SRC-1 bursts.

Test Plan:
- Single source: src_req[2]=1, 4 valid beats 0x10..0x13, last on the 4th → grant=4'b0100 one cycle after req. FIFO receives {2,0x10}..{2,0x13} on 4 consecutive cycles. busy drops; rr_ptr=3.
- All four sources request continuously, each with 4-beat bursts → grant sequence 0,1,2,3,0 with one IDLE cycle between bursts. 20 writes total, with IDs in that order.
- Length cap: source 1 sends 6 valid beats with no last → exactly 4 written and burst ends. After re-grant, the remaining 2 beats are written; the 2nd carries last and ends that burst.
- Room gating: fifo_data_count=13, req pending → no grant. Drop the count to 12 → grant on the next cycle.
- Backpressure: fifo_full=1 for 3 cycles mid-burst → src_ready=0 and fifo_wr_en=0 for those cycles. No data lost or duplicated; burst completes afterwards.
- Reset mid-burst: rst_n=0 after 2 beats → next cycle grant=0, busy=0, fifo_wr_en=0, rr_ptr=0. A subsequent request from source 3 is granted as 4'b1000.
